int_ctrl: RTL
=============

Name: int_ctrl

Overview:
Interrupt controller that sits between the peripheral IRQ lines (timer, input, output, spares) and the CPU's 6-bit hwint input.
- Latches requests into a pending register.
- Applies per-source mask and edge/level mode.
- Exposes a priority vector for the exception handler to read.
- Bus-mapped as device 3 behind the system bridge at 0x0000_7f18–0x0000_7f24. The bridge supplies we and addr[3:2].

Parameters:
NSRC, 6, number of interrupt sources. Must be ≤ 8, because the vector index is 3 bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
addr  input  2  register select (praddr[3:2]): 0 PEND, 1 MASK, 2 MODE, 3 VECTOR
we  input  1  write enable (bridge hit & wen)
wd  input  32  write data
rd  output  32  read data, combinational from addr
src_irq  input  NSRC  raw requests; already synchronous to clk
hwint  output  NSRC  pend & mask, to CPU cause register
irq  output  1  OR-reduction of hwint

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- State registers: pend[NSRC], mask[NSRC], mode[NSRC] (1 = edge, 0 = level), src_q[NSRC] (previous src_irq, for edge detection).
- Reset values:
  - pend, mask, mode, src_q all 0.
  - Therefore hwint = 0 and irq = 0.
  - rd follows addr with zeroed state; a VECTOR read returns 0.
  - Reset asserted mid-operation clears all state immediately, with no clock required.
- src_q: src_q <= src_irq every cycle.
- Edge mode (mode[i] = 1):
  - set_i = src_irq[i] & ~src_q[i].
  - pend[i] <= 1 on set_i.
  - pend[i] holds until cleared by a W1C write.
- Level mode (mode[i] = 0):
  - pend[i] <= src_irq[i] every cycle, so it follows the line with 1-cycle latency.
  - W1C writes have no lasting effect while the line stays high.
- PEND write (addr 0, we):
  - Write-1-to-clear: each bit with wd[i] = 1 clears pend[i].
  - If set_i and a clear for bit i occur in the same cycle, the set wins; the event is not lost.
- MASK write (addr 1): mask <= wd[NSRC-1:0].
- MODE write (addr 2):
  - mode <= wd[NSRC-1:0].
  - Every bit whose mode value changes has pend[i] cleared in the same cycle.
  - Level-mode bits re-sample their line on the following cycle.
- VECTOR (addr 3): read-only; writes are ignored. Reads return:
  - bit31 = valid, i.e. any bit of (pend & mask) is set.
  - bits[2:0] = lowest index i with pend[i] & mask[i]; index 0 is highest priority.
  - All other bits 0.
  - When valid = 0, bits[2:0] = 0.
- Read data: PEND, MASK and MODE reads return the register zero-extended to 32 bits.
- hwint and irq: combinational from registers, hwint = pend & mask, irq = |hwint.
- Latency:
  - A src_irq rise that is stable before posedge k makes pend, and hwint if unmasked, visible immediately after posedge k.
  - A clear write at posedge k drops hwint after posedge k.
- Masking: changing mask never alters pend. A masked pending request asserts hwint as soon as it is unmasked.
- Mode scope: mode[] affects bit NSRC-1 through 0 only; upper wd bits are ignored.

Decomposition:
- Shared package / header: NSRC default; register offsets INT_PEND = 2'd0, INT_MASK = 2'd1, INT_MODE = 2'd2, INT_VEC = 2'd3; device base address 32'h0000_7f18; VEC_VALID_BIT = 31.
- One sub-module, int_prio_enc:
  - Combinational NSRC-to-3-bit lowest-index-first priority encoder with a valid output.
  - Used for the VECTOR read.

Test Plan:
- Reset with src_irq = 6'h3f, then release reset with mask = 0 → hwint = 0, irq = 0, VECTOR read = 0x0000_0000. Write MASK = 6'h3f → level-mode pend becomes 6'h3f one cycle later, VECTOR read = 0x8000_0000.
- Level mode: MASK = 6'h01, pulse src_irq[0] high for 3 cycles → hwint[0] high for exactly 3 cycles, delayed by 1. A PEND write of 0x1 during the pulse has no lasting effect.
- Edge mode: MODE = 6'h02, MASK = 6'h02, 1-cycle pulse on src_irq[1] → hwint = 6'h02 held indefinitely, VECTOR = 0x8000_0001. Write PEND = 0x2 → hwint = 0 next cycle.
- Edge collision: new rising edge on src_irq[1] in the same cycle as PEND W1C of 0x2 → pend[1] stays 1.
- Priority: edge mode on all sources, MASK = 6'h3f, edges on sources 5, 3 and 2 → VECTOR = 0x8000_0002. Clear bit 2 → 0x8000_0003. Clear bit 3 → 0x8000_0005. Mask bit 5 → VECTOR = 0, while PEND read is still 0x20.
- Mode switch and async reset: pend[4] set in edge mode, write MODE = 0 with src_irq[4] = 0 → pend[4] cleared that cycle. Assert reset between clock edges → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: source count, register
// offsets within the device window and the VECTOR valid bit position.
package int_ctrl_pkg;

    localparam int unsigned NSRC_DEF      = 6;

    localparam logic [1:0]  INT_PEND      = 2'd0;
    localparam logic [1:0]  INT_MASK      = 2'd1;
    localparam logic [1:0]  INT_MODE      = 2'd2;
    localparam logic [1:0]  INT_VEC       = 2'd3;

    // Device 3 behind the system bridge; the bridge decodes this window.
    localparam logic [31:0] INT_BASE      = 32'h0000_7f18;

    localparam int unsigned VEC_VALID_BIT = 31;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder with valid flag; index 0 wins.
module int_prio_enc #(
    parameter int unsigned NSRC = 6
) (
    input  logic [NSRC-1:0] req,
    output logic [2:0]      idx,
    output logic            valid
);

    // Scan upward and keep the first set bit; idx stays 0 when nothing is set.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (req[i] && !valid) begin
                idx   = i[2:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending/mask/mode registers per source, edge or
// level capture, W1C clearing, and a priority vector for the handler.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = NSRC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    input  logic [NSRC-1:0] src_irq,
    output logic [NSRC-1:0] hwint,
    output logic            irq
);

    if (NSRC > 8 || NSRC < 1) begin : g_nsrc_check
        $error("int_ctrl: NSRC must be in 1..8 (3-bit vector index)");
    end

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] src_q;

    logic [NSRC-1:0] set;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] mode_chg;
    logic [NSRC-1:0] pend_next;
    logic            pend_wr;
    logic            mask_wr;
    logic            mode_wr;
    logic [2:0]      vec_idx;
    logic            vec_valid;
    logic            unused_wd;

    assign unused_wd = ^wd[31:NSRC];

    assign pend_wr  = we && (addr == INT_PEND);
    assign mask_wr  = we && (addr == INT_MASK);
    assign mode_wr  = we && (addr == INT_MODE);

    assign set      = mode & src_irq & ~src_q;
    assign clr      = pend_wr ? wd[NSRC-1:0] : '0;
    assign mode_chg = mode_wr ? (wd[NSRC-1:0] ^ mode) : '0;

    // Edge bits: set beats a same-cycle W1C. Level bits: track the line.
    // A mode change on a bit overrides both and clears it for this cycle.
    assign pend_next = ((set | (mode & pend & ~clr)) | (~mode & src_irq)) & ~mode_chg;

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend  <= '0;
            mask  <= '0;
            mode  <= '0;
            src_q <= '0;
        end else begin
            src_q <= src_irq;
            pend  <= pend_next;
            if (mask_wr) mask <= wd[NSRC-1:0];
            if (mode_wr) mode <= wd[NSRC-1:0];
        end
    end

    assign hwint = pend & mask;
    assign irq   = |hwint;

    int_prio_enc #(.NSRC(NSRC)) u_prio (
        .req   (hwint),
        .idx   (vec_idx),
        .valid (vec_valid)
    );

    // Register read mux, zero-extended to the bus width.
    always_comb begin
        rd = '0;
        case (addr)
            INT_PEND: rd[NSRC-1:0] = pend;
            INT_MASK: rd[NSRC-1:0] = mask;
            INT_MODE: rd[NSRC-1:0] = mode;
            default: begin
                rd[VEC_VALID_BIT] = vec_valid;
                rd[2:0]           = vec_idx;
            end
        endcase
    end

endmodule
